pim_bitserial_seq: RTL and testbench
====================================

Name: pim_bitserial_seq

Overview:
- Upstream controller for the bit-serial PIM macro.
- Accepts one unsigned activation vector per operation (PDEPTH lanes, ABITS bits each) on a valid/ready port.
- Streams the vector LSB-first as bit-planes onto the macro's rwl/p_en lines, then captures the registered MAC result and presents it on a valid/ready result port.
- Also provides a weight memory read/write command port, multiplexed onto the macro's d/addr/w_en lines while idle.

Parameters:
- DWIDTH, 32, MAC result width (matches macro).
- AWIDTH, 8, weight memory address width.
- PWIDTH, 32, weight word width.
- PDEPTH, 1<<AWIDTH, number of activation lanes = rwl width.
- ABITS, 8, activation bit width = number of stream cycles (2..16).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_act_data  in  PDEPTH*ABITS  lane j at bits [j*ABITS +: ABITS], unsigned.
- s_act_valid  in  1  activation vector valid.
- s_act_ready  out  1  vector accepted on valid&&ready.
- m_res_data  out  DWIDTH  dot-product result.
- m_res_valid  out  1  result valid.
- m_res_ready  in  1  result consumed.
- mem_cmd_valid  in  1  weight command valid.
- mem_cmd_ready  out  1  command accepted.
- mem_cmd_we  in  1  1 = write, 0 = read.
- mem_cmd_addr  in  AWIDTH  weight row.
- mem_cmd_wdata  in  PWIDTH  write data.
- mem_rsp_valid  out  1  one-cycle read response pulse.
- mem_rsp_data  out  PWIDTH  read data (= pim_q).
- pim_d  out  PWIDTH  to macro d.
- pim_addr  out  AWIDTH  to macro addr.
- pim_rwl  out  PDEPTH  to macro rwl.
- pim_w_en  out  1  to macro w_en.
- pim_p_en  out  1  to macro p_en.
- pim_q  in  PWIDTH  from macro q.
- pim_mac_out  in  DWIDTH  from macro mac_out (registered in macro).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0. pim_rwl=0, pim_p_en=0, pim_w_en=0, m_res_valid=0, mem_rsp_valid=0, s_act_ready=0, mem_cmd_ready=0. Result/activation registers cleared. Output drive is immediate on reset assertion, not on the next edge.
- States:
  - IDLE → STREAM on activation accept.
  - STREAM (ABITS cycles, bit counter k=0..ABITS-1) → DRAIN.
  - DRAIN (1 cycle) → CAPT.
  - CAPT (1 cycle) → RESP.
  - RESP → IDLE on m_res_valid && m_res_ready.
- IDLE:
  - s_act_ready=1.
  - mem_cmd_ready = !s_act_valid. Activation has priority over a same-cycle command.
  - pim_p_en=0, pim_rwl=0.
  - pim_w_en = mem_cmd_valid && mem_cmd_ready && mem_cmd_we.
  - pim_addr/pim_d follow mem_cmd_addr/mem_cmd_wdata combinationally.
- Read: accepted read at edge E → mem_rsp_valid=1 for the cycle after E, mem_rsp_data=pim_q. Back-to-back commands allowed, one response per read, in order. Writes give no response.
- Accept: registers s_act_data into the activation register; counter k=0.
- STREAM: pim_p_en=1, pim_w_en=0; pim_rwl[j] = act[j][k] from a registered plane, valid from the first STREAM cycle. k increments each cycle.
- DRAIN: pim_p_en=0, pim_rwl=0, pim_w_en=0. At the DRAIN-ending edge the macro loads mac_out and clears its accumulators.
- CAPT: m_res_data <= pim_mac_out at the CAPT-ending edge; m_res_valid=1 from the next cycle.
- Latency: m_res_valid rises ABITS+3 cycles after the accept edge (11 for ABITS=8).
- RESP: m_res_data and m_res_valid held stable until ready. s_act_ready=0 and mem_cmd_ready=0 in every non-IDLE state.
- Arithmetic: result = Σ_j act_j·mem[j], unsigned, modulo 2^DWIDTH (wrap, no saturation). Activation value 0 still takes the full ABITS cycles.
- Reset mid-operation: returns to IDLE with p_en=0, so the macro clears its accumulators on the next clk edge. The partial result is discarded and no response is issued.
- mem_cmd_valid held during a busy period waits; it is not dropped.

Decomposition:
- Package pim_pkg: state encoding localparams (IDLE, STREAM, DRAIN, CAPT, RESP), default widths, LAT = ABITS+3.
- One sub-module, pim_plane_slicer: parameterised combinational extract of bit k from all PDEPTH lanes, registered in the parent.

Test Plan:
- Reset: hold rst_n=0 mid-stream → all outputs 0 immediately; after release s_act_ready=1 and pim_rwl=0.
- Weight R/W: write addr 0=32'h1, addr 1=32'h3, then read addr 1 → mem_rsp_valid pulses once, data 32'h3, one cycle after accept.
- Dot product: act[0]=5, act[1]=2, others 0 → m_res_data=11, m_res_valid exactly 11 cycles after accept; pim_p_en high for exactly 8 cycles.
- Overflow: all 256 rows 32'hFFFFFFFF, all acts 255 → m_res_data=32'hFFFF0100.
- Backpressure/priority: m_res_ready low 5 cycles → data stable, s_act_ready=0. Then drive act and mem cmd valid together in IDLE → act accepted first, cmd accepted after RESP.
- Abort: assert rst_n=0 at STREAM k=3, release, rerun the dot-product test → result 11, no stale response.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared definitions for the bit-serial PIM sequencer: state encoding and default widths.
package pim_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 8;
    localparam int PWIDTH_DEF = 32;
    localparam int ABITS_DEF  = 8;
    localparam int LAT        = ABITS_DEF + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        DRAIN  = 3'd2,
        CAPT   = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/pim_plane_slicer.sv
// Pulls bit k out of every activation lane to form one rwl bit-plane (purely combinational).
module pim_plane_slicer
    import pim_pkg::*;
#(
    parameter int PDEPTH = 1 << AWIDTH_DEF,
    parameter int ABITS  = ABITS_DEF,
    parameter int KW     = $clog2(ABITS)
) (
    input  logic [PDEPTH*ABITS-1:0] act,
    input  logic [KW-1:0]           k,
    output logic [PDEPTH-1:0]       plane
);

    logic [ABITS-1:0] lane;

    always_comb begin
        lane  = '0;
        plane = '0;
        for (int j = 0; j < PDEPTH; j++) begin
            lane     = act[j*ABITS +: ABITS];
            plane[j] = lane[k];
        end
    end

endmodule

// File: rtl/pim_bitserial_seq.sv
// Controller for the bit-serial PIM macro: streams activation bit-planes LSB-first,
// captures the MAC result, and muxes weight read/write commands onto the macro while idle.
module pim_bitserial_seq
    import pim_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int PWIDTH = PWIDTH_DEF,
    parameter int PDEPTH = 1 << AWIDTH,
    parameter int ABITS  = ABITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PDEPTH*ABITS-1:0] s_act_data,
    input  logic                    s_act_valid,
    output logic                    s_act_ready,
    output logic [DWIDTH-1:0]       m_res_data,
    output logic                    m_res_valid,
    input  logic                    m_res_ready,
    input  logic                    mem_cmd_valid,
    output logic                    mem_cmd_ready,
    input  logic                    mem_cmd_we,
    input  logic [AWIDTH-1:0]       mem_cmd_addr,
    input  logic [PWIDTH-1:0]       mem_cmd_wdata,
    output logic                    mem_rsp_valid,
    output logic [PWIDTH-1:0]       mem_rsp_data,
    output logic [PWIDTH-1:0]       pim_d,
    output logic [AWIDTH-1:0]       pim_addr,
    output logic [PDEPTH-1:0]       pim_rwl,
    output logic                    pim_w_en,
    output logic                    pim_p_en,
    input  logic [PWIDTH-1:0]       pim_q,
    input  logic [DWIDTH-1:0]       pim_mac_out
);

    localparam int            KW     = $clog2(ABITS);
    localparam logic [KW-1:0] K_LAST = KW'(ABITS - 1);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [PDEPTH*ABITS-1:0] act_q, act_d;
    logic [PDEPTH-1:0]       plane_q, plane_d;
    logic [DWIDTH-1:0]       res_q, res_d;
    logic                    res_valid_q, res_valid_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    live_q;

    logic [PDEPTH*ABITS-1:0] slice_src;
    logic [KW-1:0]           slice_k;
    logic [PDEPTH-1:0]       slice_plane;
    logic                    cmd_fire;

    // The plane for the next stream cycle is prepared one cycle early so rwl comes straight from a flop.
    assign slice_src = (state_q == IDLE) ? s_act_data : act_q;
    assign slice_k   = (state_q == STREAM && k_q != K_LAST) ? k_q + KW'(1) : '0;

    pim_plane_slicer #(
        .PDEPTH (PDEPTH),
        .ABITS  (ABITS),
        .KW     (KW)
    ) u_slicer (
        .act   (slice_src),
        .k     (slice_k),
        .plane (slice_plane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            act_q       <= '0;
            plane_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            act_q       <= act_d;
            plane_q     <= plane_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            rsp_valid_q <= rsp_valid_d;
            live_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        act_d         = act_q;
        plane_d       = plane_q;
        res_d         = res_q;
        res_valid_d   = res_valid_q;
        rsp_valid_d   = 1'b0;
        cmd_fire      = 1'b0;
        s_act_ready   = 1'b0;
        mem_cmd_ready = 1'b0;
        pim_w_en      = 1'b0;
        pim_p_en      = 1'b0;
        pim_rwl       = '0;
        pim_addr      = '0;
        pim_d         = '0;

        case (state_q)
            IDLE: begin
                // live_q keeps every idle output low while reset is held and until the first clock after it.
                if (live_q) begin
                    s_act_ready   = 1'b1;
                    mem_cmd_ready = !s_act_valid;
                    pim_addr      = mem_cmd_addr;
                    pim_d         = mem_cmd_wdata;
                    cmd_fire      = mem_cmd_valid && !s_act_valid;
                    pim_w_en      = cmd_fire && mem_cmd_we;
                    rsp_valid_d   = cmd_fire && !mem_cmd_we;
                    if (s_act_valid) begin
                        act_d   = s_act_data;
                        k_d     = '0;
                        plane_d = slice_plane;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                pim_p_en = 1'b1;
                pim_rwl  = plane_q;
                plane_d  = slice_plane;
                if (k_q == K_LAST) begin
                    plane_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                state_d = CAPT;
            end
            CAPT: begin
                res_d       = pim_mac_out;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (m_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_res_data    = res_q;
    assign m_res_valid   = res_valid_q;
    assign mem_rsp_valid = rsp_valid_q;
    assign mem_rsp_data  = rsp_valid_q ? pim_q : '0;

endmodule

// File: tb/tb_pim_bitserial_seq.sv
// Scoreboard bench for pim_bitserial_seq with a behavioural PIM macro and a dot-product reference model.
module tb_pim_bitserial_seq;

    localparam int AW = 8;
    localparam int PD = 1 << AW;
    localparam int AB = 8;
    localparam int DW = 32;
    localparam int PW = 32;

    logic               clk;
    logic               rst_n;
    logic [PD*AB-1:0]   s_act_data;
    logic               s_act_valid;
    logic               s_act_ready;
    logic [DW-1:0]      m_res_data;
    logic               m_res_valid;
    logic               m_res_ready;
    logic               mem_cmd_valid;
    logic               mem_cmd_ready;
    logic               mem_cmd_we;
    logic [AW-1:0]      mem_cmd_addr;
    logic [PW-1:0]      mem_cmd_wdata;
    logic               mem_rsp_valid;
    logic [PW-1:0]      mem_rsp_data;
    logic [PW-1:0]      pim_d;
    logic [AW-1:0]      pim_addr;
    logic [PD-1:0]      pim_rwl;
    logic               pim_w_en;
    logic               pim_p_en;
    logic [PW-1:0]      pim_q = '0;
    logic [DW-1:0]      pim_mac_out = '0;

    pim_bitserial_seq #(
        .DWIDTH (DW), .AWIDTH (AW), .PWIDTH (PW), .PDEPTH (PD), .ABITS (AB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_act_data    (s_act_data),
        .s_act_valid   (s_act_valid),
        .s_act_ready   (s_act_ready),
        .m_res_data    (m_res_data),
        .m_res_valid   (m_res_valid),
        .m_res_ready   (m_res_ready),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .pim_d         (pim_d),
        .pim_addr      (pim_addr),
        .pim_rwl       (pim_rwl),
        .pim_w_en      (pim_w_en),
        .pim_p_en      (pim_p_en),
        .pim_q         (pim_q),
        .pim_mac_out   (pim_mac_out)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural macro ----------------
    logic [PW-1:0] mem_m [PD] = '{default: '0};
    logic [DW-1:0] mac_acc = '0;
    int            pcnt = 0;

    function automatic logic [DW-1:0] plane_sum(input logic [PD-1:0] rwl);
        logic [DW-1:0] s = '0;
        for (int j = 0; j < PD; j++) if (rwl[j]) s = s + DW'(mem_m[j]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (pim_w_en) mem_m[pim_addr] <= pim_d;
        pim_q <= mem_m[pim_addr];
        if (pim_p_en) begin
            mac_acc <= mac_acc + (plane_sum(pim_rwl) << pcnt);
            pcnt    <= pcnt + 1;
        end else if (pcnt != 0) begin
            pim_mac_out <= mac_acc;
            mac_acc     <= '0;
            pcnt        <= 0;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [PW-1:0] shadow [PD] = '{default: '0};

    function automatic logic [DW-1:0] ref_dot(input logic [PD*AB-1:0] v);
        logic [63:0] s = '0;
        for (int j = 0; j < PD; j++) s = s + 64'(v[j*AB +: AB]) * 64'(shadow[j]);
        return s[DW-1:0];
    endfunction

    logic [DW-1:0] res_exp_q [$];
    int            res_cyc_q [$];
    int            pen_q [$];
    logic [PW-1:0] rsp_exp_q [$];
    int            rsp_cyc_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit outs_zero();
        return ({s_act_ready, mem_cmd_ready, m_res_valid, mem_rsp_valid, pim_w_en, pim_p_en} == 6'b0)
            && (m_res_data == '0) && (mem_rsp_data == '0) && (pim_d == '0)
            && (pim_addr == '0) && (pim_rwl == '0);
    endfunction

    // ---------------- monitor ----------------
    int pen_total = 0;
    int res_fire_cyc = 0;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pim_p_en) pen_total = pen_total + 1;
            if (m_res_valid) begin
                if (!prev_valid && res_cyc_q.size() > 0) begin
                    chk("res_latency", 64'(cyc), 64'(res_cyc_q.pop_front()));
                    chk("pen_cycles", 64'(pen_total - pen_q.pop_front()), 64'(AB));
                end
                if (res_exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    chk("res_data", 64'(m_res_data), 64'(res_exp_q[0]));
                    chk("busy_ready", {s_act_ready, mem_cmd_ready}, 0);
                    if (m_res_ready) begin
                        void'(res_exp_q.pop_front());
                        res_fire_cyc = cyc;
                    end
                end
            end
            if (mem_rsp_valid) begin
                if (rsp_exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_data", 64'(mem_rsp_data), 64'(rsp_exp_q.pop_front()));
                    chk("rsp_latency", 64'(cyc), 64'(rsp_cyc_q.pop_front()));
                end
            end
        end
        prev_valid = m_res_valid;
    end

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [PW-1:0] data,
                            output int fire_cyc);
        int n = 0;
        bit ok = 1'b1;
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = we;
        mem_cmd_addr  = addr;
        mem_cmd_wdata = data;
        @(negedge clk);
        while (!mem_cmd_ready) begin
            n++;
            if (n > 300) begin
                chk("cmd_timeout", 1, 0);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        fire_cyc = cyc;
        if (ok) begin
            if (we) begin
                shadow[addr] = data;
            end else begin
                rsp_exp_q.push_back(shadow[addr]);
                rsp_cyc_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
        mem_cmd_valid = 1'b0;
    endtask

    task automatic send_act(input logic [PD*AB-1:0] v, output int fire_cyc);
        int n = 0;
        bit ok = 1'b1;
        s_act_data  = v;
        s_act_valid = 1'b1;
        @(negedge clk);
        while (!s_act_ready) begin
            n++;
            if (n > 300) begin
                chk("act_timeout", 1, 0);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        fire_cyc = cyc;
        if (ok) begin
            res_exp_q.push_back(ref_dot(v));
            res_cyc_q.push_back(cyc + AB + 3);
            pen_q.push_back(pen_total);
        end
        @(posedge clk);
        #1;
        s_act_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (res_exp_q.size() != 0 || rsp_exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                chk("drain_timeout", 1, 0);
                res_exp_q.delete();
                res_cyc_q.delete();
                pen_q.delete();
                rsp_exp_q.delete();
                rsp_cyc_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [PD*AB-1:0] v;
    logic [PD*AB-1:0] v_dot;
    int ca, cc, c;

    initial begin
        rst_n         = 1'b0;
        s_act_data    = '0;
        s_act_valid   = 1'b0;
        m_res_ready   = 1'b1;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_wdata = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs_zero", outs_zero(), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_act_ready", s_act_ready, 1);
        chk("idle_cmd_ready", mem_cmd_ready, 1);
        chk("idle_rwl_zero", pim_rwl, 0);
        @(posedge clk);
        #1;

        // weight write then back-to-back reads
        send_cmd(1'b1, 8'd0, 32'h1, c);
        send_cmd(1'b1, 8'd1, 32'h3, c);
        send_cmd(1'b0, 8'd1, '0, c);
        send_cmd(1'b0, 8'd0, '0, c);
        drain();

        // directed dot product: 5*1 + 2*3 = 11
        v_dot = '0;
        v_dot[0*AB +: AB] = 8'd5;
        v_dot[1*AB +: AB] = 8'd2;
        send_act(v_dot, c);
        drain();

        // randomized weights and activations, last round all-zero activations
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++)
                send_cmd(1'b1, AW'($urandom_range(0, PD - 1)), $urandom, c);
            send_cmd(1'b0, AW'($urandom_range(0, PD - 1)), '0, c);
            send_cmd(1'b0, AW'($urandom_range(0, PD - 1)), '0, c);
            for (int j = 0; j < PD; j++) v[j*AB +: AB] = AB'($urandom_range(0, 255));
            if (r == 3) v = '0;
            send_act(v, c);
            drain();
        end

        // wrap-around: all weights and all activations at maximum
        for (int a = 0; a < PD; a++) send_cmd(1'b1, AW'(a), 32'hFFFF_FFFF, c);
        v = '1;
        chk("overflow_model", 64'(ref_dot(v)), 64'h0000_0000_FFFF_0100);
        send_act(v, c);
        drain();

        // backpressure with simultaneous activation and command in idle
        send_cmd(1'b1, 8'd0, 32'h1, c);
        send_cmd(1'b1, 8'd1, 32'h3, c);
        m_res_ready = 1'b0;
        fork
            send_act(v_dot, ca);
            send_cmd(1'b1, 8'd9, 32'h1234, cc);
            begin
                int n = 0;
                @(negedge clk);
                while (!m_res_valid && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                chk("bp_valid_seen", m_res_valid, 1);
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1;
                m_res_ready = 1'b1;
            end
        join
        chk("prio_act_first", ca < cc, 1);
        chk("cmd_after_resp", 64'(cc), 64'(res_fire_cyc + 1));
        drain();

        // abort at stream bit 3, then rerun
        send_act(v_dot, c);
        repeat (3) @(posedge clk);
        #3;
        chk("abort_in_stream", pim_p_en, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", outs_zero(), 1);
        res_exp_q.delete();
        res_cyc_q.delete();
        pen_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_act(v_dot, c);
        drain();
        repeat (20) @(posedge clk);
        chk("res_queue_empty", 64'(res_exp_q.size()), 0);
        chk("rsp_queue_empty", 64'(rsp_exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
